stopwatch_ctrl: RTL and testbench

- Sequencing controller for a mm:ss stopwatch built from four cascaded mod-6/mod-10 digit counters: seconds-ones (mod 10), seconds-tens (mod 6), minutes-ones (mod 10), minutes-tens (mod 6).
- Divides `clk` down to a count tick, then generates per-digit `incr` strobes with carry ripple from the live digit values.
- Runs a start/stop/lap/clear state machine that drives a shared synchronous clear, and presents a displayable (optionally lap-frozen) digit bus.

---
 rtl/stopwatch_ctrl_if.sv | 26 ++
 rtl/stopwatch_ctrl.sv | 134 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - control, digit and display signals of the stopwatch sequencer
// master drives pulses and live digits; slave is the controller.
interface stopwatch_ctrl_if;
  logic        start_stop;
  logic        lap_clr;
  logic [3:0]  sec_ones;
  logic [2:0]  sec_tens;
  logic [3:0]  min_ones;
  logic [2:0]  min_tens;
  logic [3:0]  incr;
  logic        clr;
  logic [13:0] disp;
  logic        running;
  logic        frozen;
  logic        rollover;

  modport master (
    output start_stop, lap_clr, sec_ones, sec_tens, min_ones, min_tens,
    input  incr, clr, disp, running, frozen, rollover
  );

  modport slave (
    input  start_stop, lap_clr, sec_ones, sec_tens, min_ones, min_tens,
    output incr, clr, disp, running, frozen, rollover
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - mm:ss stopwatch sequencer: prescaler, carry strobes, run/pause/lap/clear FSM
// Lap freeze (LAP state, frozen output) is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 100
) (
  input logic            clk,
  input logic            reset,
  stopwatch_ctrl_if.slave sw
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [3:0]     incr_q, incr_d;
  logic           clr_q, clr_d;
  logic           roll_q, roll_d;
  logic [13:0]    disp_q, disp_d;
  logic           running_q;
  logic [13:0]    live;
  logic           counting;
  logic           tick;
`ifdef STOPWATCH_LAP_EN
  logic           frozen_q;
`endif

  assign live = {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones};

  always_comb begin
    counting = (state_q == S_RUN) || (state_q == S_LAP);
    tick     = counting && (presc_q == PRESC_MAX);

    presc_d = presc_q;
    if (counting) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Carry ripple is taken from the live digits, so counters wrap on their own.
    incr_d = '0;
    roll_d = 1'b0;
    if (tick) begin
      incr_d[0] = 1'b1;
      incr_d[1] = (sw.sec_ones == 4'd9);
      incr_d[2] = incr_d[1] && (sw.sec_tens == 3'd5);
      incr_d[3] = incr_d[2] && (sw.min_ones == 4'd9);
      roll_d    = incr_d[3] && (sw.min_tens == 3'd5);
    end

    state_d = state_q;
    clr_d   = 1'b0;
    if (sw.start_stop) begin
      case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_RUN;
        S_LAP:   state_d = S_PAUSE;
        default: state_d = S_IDLE;
      endcase
    end else if (sw.lap_clr) begin
      case (state_q)
        S_IDLE:  clr_d = 1'b1;
        S_RUN: begin
`ifdef STOPWATCH_LAP_EN
          state_d = S_LAP;
`endif
        end
        S_PAUSE: begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
        end
        S_LAP:   state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d == S_IDLE) begin
      presc_d = '0;
    end

    // disp_q doubles as the freeze register: entering LAP captures, staying in LAP holds.
    disp_d = live;
`ifdef STOPWATCH_LAP_EN
    if ((state_q == S_LAP) && (state_d == S_LAP)) begin
      disp_d = disp_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      incr_q    <= '0;
      clr_q     <= 1'b1;
      roll_q    <= 1'b0;
      disp_q    <= '0;
      running_q <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      frozen_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      incr_q    <= incr_d;
      clr_q     <= clr_d;
      roll_q    <= roll_d;
      disp_q    <= disp_d;
      running_q <= (state_d == S_RUN) || (state_d == S_LAP);
`ifdef STOPWATCH_LAP_EN
      frozen_q  <= (state_d == S_LAP);
`endif
    end
  end

  assign sw.incr     = incr_q;
  assign sw.clr      = clr_q;
  assign sw.rollover = roll_q;
  assign sw.disp     = disp_q;
  assign sw.running  = running_q;
`ifdef STOPWATCH_LAP_EN
  assign sw.frozen   = frozen_q;
`else
  assign sw.frozen   = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - randomized bench for stopwatch_ctrl against a cycle-count reference model
// Digit counters are bench models clocked by the DUT strobes; the lap path follows STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;

  localparam int TD = 4;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_LAP   = 3;

  logic clk = 1'b0;
  logic reset;
  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Live digit counters (environment) and controller reference model.
  int          so = 0, st = 0, mo = 0, mt = 0;
  logic [3:0]  p_incr = '0;
  logic        p_clr = 1'b0;
  int          m_mode = M_IDLE;
  int          m_cnt = 0;
  logic [3:0]  e_incr;
  logic        e_clr, e_roll, e_run, e_frz;
  logic [13:0] e_disp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_digits();
    sw_if.sec_ones = 4'(so);
    sw_if.sec_tens = 3'(st);
    sw_if.min_ones = 4'(mo);
    sw_if.min_tens = 3'(mt);
  endtask

  // Expected controller outputs after one clock edge, from elapsed running cycles and total seconds.
  task automatic model_edge(input bit ss, input bit lc, input bit rst);
    int total, nxt, old;
    bit counting, tick;
    total = mt * 600 + mo * 60 + st * 10 + so;
    if (!rst) begin
      m_mode = M_IDLE; m_cnt = 0;
      e_clr = 1'b1; e_incr = '0; e_roll = 1'b0; e_disp = '0; e_run = 1'b0; e_frz = 1'b0;
      return;
    end
    counting = (m_mode == M_RUN) || (m_mode == M_LAP);
    tick = counting && (((m_cnt + 1) % TD) == 0);
    if (counting) m_cnt++;
    nxt = total + 1;
    e_incr = tick ? {nxt % 600 == 0, nxt % 60 == 0, nxt % 10 == 0, 1'b1} : 4'b0000;
    e_roll = tick && (nxt % 3600 == 0);
    old = m_mode;
    e_clr = 1'b0;
    if (ss) begin
      m_mode = (old == M_RUN || old == M_LAP) ? M_PAUSE : M_RUN;
    end else if (lc) begin
      if (old == M_IDLE) e_clr = 1'b1;
      else if (old == M_RUN && LAP_EN) m_mode = M_LAP;
      else if (old == M_LAP) m_mode = M_RUN;
      else if (old == M_PAUSE) begin
        m_mode = M_IDLE;
        e_clr = 1'b1;
      end
    end
    if (m_mode == M_IDLE) m_cnt = 0;
    if (!(old == M_LAP && m_mode == M_LAP)) e_disp = 14'(so + st * 16 + mo * 128 + mt * 2048);
    e_run = (m_mode == M_RUN) || (m_mode == M_LAP);
    e_frz = (m_mode == M_LAP);
  endtask

  task automatic step(input bit ss, input bit lc, input bit rst);
    sw_if.start_stop = ss;
    sw_if.lap_clr    = lc;
    reset            = rst;
    @(posedge clk);
    #1;
    model_edge(ss, lc, rst);
    if (p_clr) begin
      so = 0; st = 0; mo = 0; mt = 0;
    end else begin
      if (p_incr[0]) so = (so + 1) % 10;
      if (p_incr[1]) st = (st + 1) % 6;
      if (p_incr[2]) mo = (mo + 1) % 10;
      if (p_incr[3]) mt = (mt + 1) % 6;
    end
    drive_digits();
    check("incr", sw_if.incr, e_incr);
    check("rollover", sw_if.rollover, e_roll);
    check("clr", sw_if.clr, e_clr);
    check("disp", sw_if.disp, e_disp);
    check("running", sw_if.running, e_run);
    check("frozen", sw_if.frozen, e_frz);
    p_incr = sw_if.incr;
    p_clr  = sw_if.clr;
    sw_if.start_stop = 1'b0;
    sw_if.lap_clr    = 1'b0;
  endtask

  task automatic wait_incr(output int n, input int bound);
    n = 0;
    do begin
      step(1'b0, 1'b0, 1'b1);
      n++;
    end while (sw_if.incr == 4'b0000 && n < bound);
  endtask

  initial begin
    int n;
    int r;
    logic [13:0] exp_lap;
    sw_if.start_stop = 1'b0;
    sw_if.lap_clr    = 1'b0;
    reset            = 1'b0;
    drive_digits();

    // Reset
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("rst_clr", sw_if.clr, 1);
    check("rst_running", sw_if.running, 0);
    step(1'b0, 1'b0, 1'b1);
    check("rst_clr_release", sw_if.clr, 0);
    check("rst_disp", sw_if.disp, 0);

    // Counting and carry into seconds-tens
    step(1'b1, 1'b0, 1'b1);
    wait_incr(n, 20);
    check("first_tick_latency", n, 4);
    repeat (40) step(1'b0, 1'b0, 1'b1);
    check("disp_00_10", sw_if.disp, 14'h010);

    // Rollover from 59:59
    step(1'b0, 1'b0, 1'b1);
    so = 9; st = 5; mo = 9; mt = 5;
    drive_digits();
    wait_incr(n, 8);
    check("roll_incr", sw_if.incr, 4'hf);
    check("roll_pulse", sw_if.rollover, 1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("roll_disp", sw_if.disp, 0);

    // Pause with prescaler held at 2, then resume
    wait_incr(n, 8);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    wait_incr(n, 8);
    check("resume_latency", n, 2);

    // Simultaneous pulses in PAUSE, then clear
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("both_running", sw_if.running, 1);
    check("both_no_clr", sw_if.clr, 0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("clear_clr", sw_if.clr, 1);
    check("clear_running", sw_if.running, 0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("clear_disp", sw_if.disp, 0);

    // Lap at 00:03
    step(1'b1, 1'b0, 1'b1);
    repeat (13) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("lap_capture", sw_if.disp, 14'h003);
    check("lap_frozen", sw_if.frozen, LAP_EN);
    repeat (8) step(1'b0, 1'b0, 1'b1);
    exp_lap = LAP_EN ? 14'h003 : 14'(so + st * 16 + mo * 128 + mt * 2048);
    check("lap_hold", sw_if.disp, exp_lap);
    step(1'b0, 1'b1, 1'b1);
    check("lap_release", sw_if.frozen, 0);

    // Randomized pulses, occasional resets and digit presets near carry boundaries
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      if (r < 2) step(1'b1, 1'b1, 1'b1);
      else if (r < 10) step(1'b1, 1'b0, 1'b1);
      else if (r < 18) step(1'b0, 1'b1, 1'b1);
      else if (r == 199) step(1'b0, 1'b0, 1'b0);
      else step(1'b0, 1'b0, 1'b1);
      if (r >= 190 && r < 195 && p_incr == 4'b0000 && !p_clr) begin
        so = $urandom_range(0, 1) ? 9 : $urandom_range(0, 9);
        st = $urandom_range(0, 1) ? 5 : $urandom_range(0, 5);
        mo = $urandom_range(0, 1) ? 9 : $urandom_range(0, 9);
        mt = $urandom_range(0, 1) ? 5 : $urandom_range(0, 5);
        drive_digits();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
